gpr_wb_arb: RTL and testbench
=============================

Name: gpr_wb_arb

Overview:
- Shares the single GPR write port between the writeback sources: ALU, load unit and mul/div unit.
- Round-robin arbitration of requests; drives the registered WrEn/OFWrEn/OFFlag/WrAddr/WrData inputs of gpr.
- Keeps a pending-write scoreboard (busy bit per register) that the issue stage reserves and hazard logic queries.

Parameters:
- NREQ, 3, number of write requesters. Index 0 = ALU, 1 = load, 2 = mul/div.
- RR_EN, 1, 1 = round-robin, 0 = fixed priority (lowest index wins).

Ports:
- clk  in  1  clock, all state on posedge
- rst  in  1  synchronous reset, active high
- Req  in  NREQ  per-requester write request
- ReqAddr  in  NREQ*5  destination register, requester i at bits [5i+4:5i]
- ReqData  in  NREQ*32  write data, requester i at bits [32i+31:32i]
- ReqOFWrEn  in  NREQ  write is overflow-conditional
- ReqOFFlag  in  NREQ  overflow result for that write
- Gnt  out  NREQ  one-hot grant, combinational
- WrEn  out  1  to gpr, registered
- OFWrEn  out  1  to gpr, registered
- OFFlag  out  1  to gpr, registered
- WrAddr  out  5  to gpr, registered
- WrData  out  32  to gpr, registered
- Reserve  in  1  issue stage marks ResAddr as pending
- ResAddr  in  5  register being reserved
- ResStall  out  1  reservation refused, issue must hold
- ChkAddr1  in  5  hazard query address 1
- ChkAddr2  in  5  hazard query address 2
- Busy1  out  1  busy[ChkAddr1], combinational
- Busy2  out  1  busy[ChkAddr2], combinational

Behaviour:
- Reset (rst=1 at posedge):
  - WrEn=0, OFWrEn=0, OFFlag=0, WrAddr=0, WrData=0.
  - busy[31:0]=0, rr pointer ptr=0.
  - Gnt forced 0 and ResStall forced 0 while rst is high; any request or reserve presented during reset is dropped.
- Handshake:
  - A requester holds Req, Addr, Data and OF bits stable until it sees Gnt.
  - A transfer occurs in a cycle with Req[i] & Gnt[i].
  - The output stage accepts every cycle, so Gnt never waits on downstream.
- Arbitration:
  - RR_EN=1: scan indices ptr, ptr+1, ... mod NREQ; the first with Req set is granted. After a grant to i, ptr <= (i+1) mod NREQ. With no request, ptr is unchanged.
  - RR_EN=0: lowest asserted index wins; ptr is unused.
  - At most one Gnt bit is set per cycle.
- Output stage, latency 1:
  - On a transfer from i, the next posedge loads WrEn=1, WrAddr, WrData, OFWrEn, OFFlag from requester i.
  - With no transfer, WrEn=0 and OFWrEn=0; the other fields hold their values.
  - gpr commits at the following posedge, so write data is readable 2 edges after the grant cycle.
- Scoreboard:
  - Reserve & !ResStall & ResAddr!=0 sets busy[ResAddr] at the posedge.
  - When the output stage holds WrEn=1, busy[WrAddr] clears at the posedge, the same edge gpr writes. This also applies when OFWrEn & OFFlag suppress the write.
  - ResStall = Reserve & busy[ResAddr] & !(WrEn & WrAddr==ResAddr).
  - Same-cycle clear and set of the same register: the set wins and busy stays 1.
  - Register 0 is never busy; Reserve to 0 is accepted and ignored.
  - Writes to address 0 are still granted and forwarded; gpr discards them.
  - Busy1 and Busy2 read busy directly with no bypass. The clearing edge and the gpr write coincide.

Decomposition:
- Add to defines.v: REQ_ALU=0, REQ_LSU=1, REQ_MDU=2, REG_ZERO=0, REG_OF=30, and width constants REG_AW=5, REG_DW=32.
- One sub-module, rr_arbiter (NREQ, RR_EN): takes Req, produces one-hot Gnt, and holds the ptr state and its update.
- Scoreboard and output register stay in gpr_wb_arb.

Test Plan:
- Reset, then single write: Req=3'b001, Addr=5, Data=32'h12345678.
  - Gnt=001 the same cycle.
  - Next cycle WrEn=1, WrAddr=5.
  - Two edges after grant, gpr reg 5 = 32'h12345678.
- Round robin: Req=3'b111 held for 6 cycles → Gnt sequence 001, 010, 100, 001, 010, 100. With RR_EN=0, Gnt stays 001 throughout.
- Overflow forwarding:
  - ALU writes addr 1 with OFWrEn=1, OFFlag=0 → reg 1 = 32'h87654321 and reg 30 bit 0 = 0.
  - ALU writes addr 2 with OFFlag=1 → reg 2 unchanged, reg 30 bit 0 = 1, and busy[2] still clears.
- Scoreboard:
  - Reserve addr 7 → Busy1=1 for ChkAddr1=7 the next cycle.
  - Reserve 7 again → ResStall=1.
  - Load write to 7 → ResStall drops in the commit cycle, busy[7] stays 1 after the same-edge clear and set.
  - Reserve addr 0 → Busy=0 and ResStall=0.
- Reset mid-operation: Req=3'b110 and busy[3]=1, assert rst for 1 cycle → Gnt=0, and the next cycle WrEn=0, busy=0, ptr=0. The following grant goes to index 1.

Source files
------------

// File: rtl/gpr_wb_arb_pkg.sv
// Shared constants and types for the GPR writeback arbiter.
//   REQ_*     : requester slot indices (ALU, load unit, mul/div unit)
//   REG_*     : register file geometry and special register numbers
//   wrReq_t   : one writeback request as forwarded to the gpr write port
package gpr_wb_arb_pkg;

    localparam int REQ_ALU = 0;
    localparam int REQ_LSU = 1;
    localparam int REQ_MDU = 2;

    localparam int REG_AW = 5;
    localparam int REG_DW = 32;

    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;
    localparam logic [REG_AW-1:0] REG_OF   = 5'd30;

    typedef struct packed {
        logic              ofWrEn;
        logic              ofFlag;
        logic [REG_AW-1:0] addr;
        logic [REG_DW-1:0] data;
    } wrReq_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin / fixed-priority arbiter with a one-hot combinational grant.
//   clk, rst : clock, synchronous active-high reset
//   req      : per-requester request
//   gnt      : one-hot grant, forced to zero while rst is high
// RR_EN=1 scans from ptr upward (mod NREQ) and moves ptr past the winner;
// RR_EN=0 grants the lowest asserted index and leaves ptr idle.
module rr_arbiter #(
    parameter int NREQ  = 3,
    parameter bit RR_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] idx;
    logic [PW-1:0] gntIdx;
    logic [PW:0]   sum;
    logic          found;

    always_comb begin
        gnt    = '0;
        gntIdx = '0;
        found  = 1'b0;
        sum    = '0;
        idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            // ptr + k never reaches 2*NREQ, so one conditional subtract is the modulo
            sum = (RR_EN ? {1'b0, ptr} : '0) + (PW+1)'(k);
            if (sum >= (PW+1)'(NREQ))
                sum = sum - (PW+1)'(NREQ);
            idx = sum[PW-1:0];
            if (!found && req[idx]) begin
                found  = 1'b1;
                gntIdx = idx;
            end
        end
        if (found && !rst)
            gnt[gntIdx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (RR_EN && found)
            ptr <= (gntIdx == PW'(NREQ-1)) ? '0 : gntIdx + PW'(1);
    end

endmodule

// File: rtl/gpr_wb_arb.sv
// GPR writeback arbiter: shares the single gpr write port between the ALU,
// load unit and mul/div unit, and tracks pending writes per register.
//   clk, rst        : clock, synchronous active-high reset
//   Req/ReqAddr/ReqData/ReqOFWrEn/ReqOFFlag : packed per-requester write requests
//   Gnt             : one-hot combinational grant (a grant is a transfer)
//   WrEn/OFWrEn/OFFlag/WrAddr/WrData : registered gpr write port
//   Reserve/ResAddr/ResStall : issue-stage reservation of a destination register
//   ChkAddr1/2, Busy1/2      : hazard queries on the pending-write scoreboard
module gpr_wb_arb
    import gpr_wb_arb_pkg::*;
#(
    parameter int NREQ  = 3,
    parameter bit RR_EN = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        Req,
    input  logic [NREQ*REG_AW-1:0] ReqAddr,
    input  logic [NREQ*REG_DW-1:0] ReqData,
    input  logic [NREQ-1:0]        ReqOFWrEn,
    input  logic [NREQ-1:0]        ReqOFFlag,
    output logic [NREQ-1:0]        Gnt,
    output logic                   WrEn,
    output logic                   OFWrEn,
    output logic                   OFFlag,
    output logic [REG_AW-1:0]      WrAddr,
    output logic [REG_DW-1:0]      WrData,
    input  logic                   Reserve,
    input  logic [REG_AW-1:0]      ResAddr,
    output logic                   ResStall,
    input  logic [REG_AW-1:0]      ChkAddr1,
    input  logic [REG_AW-1:0]      ChkAddr2,
    output logic                   Busy1,
    output logic                   Busy2
);

    wrReq_t      sel;
    logic        xfer;
    logic [31:0] busy;
    logic [31:0] busyNext;

    rr_arbiter #(.NREQ(NREQ), .RR_EN(RR_EN)) uArb (
        .clk (clk),
        .rst (rst),
        .req (Req),
        .gnt (Gnt)
    );

    // Gnt is only ever raised on a requesting index, so any grant is a transfer.
    assign xfer = |Gnt;

    always_comb begin
        sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (Gnt[i]) begin
                sel.ofWrEn = ReqOFWrEn[i];
                sel.ofFlag = ReqOFFlag[i];
                sel.addr   = ReqAddr[i*REG_AW +: REG_AW];
                sel.data   = ReqData[i*REG_DW +: REG_DW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            WrEn   <= 1'b0;
            OFWrEn <= 1'b0;
            OFFlag <= 1'b0;
            WrAddr <= '0;
            WrData <= '0;
        end else begin
            WrEn   <= xfer;
            OFWrEn <= xfer & sel.ofWrEn;
            if (xfer) begin
                OFFlag <= sel.ofFlag;
                WrAddr <= sel.addr;
                WrData <= sel.data;
            end
        end
    end

    // A register whose write is committing this edge can be re-reserved
    // without stalling; the set below then overrides the clear.
    assign ResStall = !rst && Reserve && busy[ResAddr]
                      && !(WrEn && (WrAddr == ResAddr));

    always_comb begin
        busyNext = busy;
        if (WrEn)
            busyNext[WrAddr] = 1'b0;
        if (Reserve && !ResStall && (ResAddr != REG_ZERO))
            busyNext[ResAddr] = 1'b1;
        busyNext[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            busy <= '0;
        else
            busy <= busyNext;
    end

    // No bypass: the clearing edge coincides with the gpr write.
    assign Busy1 = busy[ChkAddr1];
    assign Busy2 = busy[ChkAddr2];

endmodule

// File: tb/tb_gpr_wb_arb.sv
module tb_gpr_wb_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  Req;
    logic [14:0] ReqAddr;
    logic [95:0] ReqData;
    logic [2:0]  ReqOFWrEn;
    logic [2:0]  ReqOFFlag;
    logic        Reserve;
    logic [4:0]  ResAddr;
    logic [4:0]  ChkAddr1;
    logic [4:0]  ChkAddr2;

    logic [2:0]  Gnt;
    logic        WrEn, OFWrEn, OFFlag, ResStall, Busy1, Busy2;
    logic [4:0]  WrAddr;
    logic [31:0] WrData;

    logic [2:0]  GntF;
    logic        WrEnF, OFWrEnF, OFFlagF, ResStallF, Busy1F, Busy2F;
    logic [4:0]  WrAddrF;
    logic [31:0] WrDataF;

    logic [31:0] gprRegs [32];

    int nChk  = 0;
    int nPass = 0;

    always #5 clk = ~clk;

    gpr_wb_arb #(.NREQ(3), .RR_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .Req(Req), .ReqAddr(ReqAddr), .ReqData(ReqData),
        .ReqOFWrEn(ReqOFWrEn), .ReqOFFlag(ReqOFFlag), .Gnt(Gnt),
        .WrEn(WrEn), .OFWrEn(OFWrEn), .OFFlag(OFFlag), .WrAddr(WrAddr), .WrData(WrData),
        .Reserve(Reserve), .ResAddr(ResAddr), .ResStall(ResStall),
        .ChkAddr1(ChkAddr1), .ChkAddr2(ChkAddr2), .Busy1(Busy1), .Busy2(Busy2)
    );

    gpr_wb_arb #(.NREQ(3), .RR_EN(1'b0)) dutFixed (
        .clk(clk), .rst(rst), .Req(Req), .ReqAddr(ReqAddr), .ReqData(ReqData),
        .ReqOFWrEn(ReqOFWrEn), .ReqOFFlag(ReqOFFlag), .Gnt(GntF),
        .WrEn(WrEnF), .OFWrEn(OFWrEnF), .OFFlag(OFFlagF), .WrAddr(WrAddrF), .WrData(WrDataF),
        .Reserve(Reserve), .ResAddr(ResAddr), .ResStall(ResStallF),
        .ChkAddr1(ChkAddr1), .ChkAddr2(ChkAddr2), .Busy1(Busy1F), .Busy2(Busy2F)
    );

    // Minimal gpr model: an overflow-conditional write with OFFlag=1 is
    // suppressed, and every OF write records the flag in bit 0 of reg 30.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) gprRegs[i] <= '0;
        end else if (WrEn) begin
            if (!(OFWrEn && OFFlag) && WrAddr != 5'd0)
                gprRegs[WrAddr] <= WrData;
            if (OFWrEn)
                gprRegs[30][0] <= OFFlag;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChk++;
        if (got !== exp)
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        else
            nPass++;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic setReq(input int i, input logic [4:0] a, input logic [31:0] d,
                          input logic ofw, input logic off);
        Req[i]              = 1'b1;
        ReqAddr[i*5 +: 5]   = a;
        ReqData[i*32 +: 32] = d;
        ReqOFWrEn[i]        = ofw;
        ReqOFFlag[i]        = off;
    endtask

    task automatic clrReq;
        Req = '0; ReqAddr = '0; ReqData = '0; ReqOFWrEn = '0; ReqOFFlag = '0;
    endtask

    initial begin
        rst = 1'b1; clrReq();
        Reserve = 1'b0; ResAddr = '0; ChkAddr1 = '0; ChkAddr2 = '0;
        tick(); tick();
        chk("rst_wren",   WrEn,   0);
        chk("rst_ofwren", OFWrEn, 0);
        chk("rst_wraddr", WrAddr, 0);
        chk("rst_wrdata", WrData, 0);

        // request presented during reset is dropped
        setReq(0, 5'd5, 32'h12345678, 1'b0, 1'b0);
        #1;
        chk("rst_gnt_zero", Gnt, 0);
        tick();
        chk("rst_req_dropped", WrEn, 0);

        // single write
        rst = 1'b0;
        #1;
        chk("single_gnt", Gnt, 3'b001);
        tick();
        clrReq();
        chk("single_wren",   WrEn,   1);
        chk("single_wraddr", WrAddr, 5);
        chk("single_wrdata", WrData, 32'h12345678);
        tick();
        chk("single_wren_drop", WrEn, 0);
        chk("single_reg5", gprRegs[5], 32'h12345678);

        // round robin from ptr=0, fixed priority alongside
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 3; i++) setReq(i, 5'(10 + i), 32'(100 + i), 1'b0, 1'b0);
        for (int c = 0; c < 6; c++) begin
            #1;
            chk("rr_gnt", Gnt, 32'(1 << (c % 3)));
            chk("fp_gnt", GntF, 3'b001);
            tick();
            chk("rr_wraddr", WrAddr, 32'(10 + c % 3));
            chk("rr_wrdata", WrData, 32'(100 + c % 3));
        end
        clrReq();
        chk("fp_wraddr", WrAddrF, 10);

        // overflow-conditional write, flag clear
        setReq(0, 5'd1, 32'h87654321, 1'b1, 1'b0);
        #1;
        chk("of0_gnt", Gnt, 3'b001);
        tick();
        clrReq();
        chk("of0_wren",   WrEn,   1);
        chk("of0_ofwren", OFWrEn, 1);
        chk("of0_offlag", OFFlag, 0);
        tick();
        chk("of0_reg1",  gprRegs[1], 32'h87654321);
        chk("of0_reg30", gprRegs[30][0], 0);
        chk("of0_ofwren_drop", OFWrEn, 0);

        // overflow-suppressed write still clears busy
        Reserve = 1'b1; ResAddr = 5'd2;
        #1;
        chk("res2_stall", ResStall, 0);
        tick();
        Reserve = 1'b0; ChkAddr1 = 5'd2;
        #1;
        chk("res2_busy", Busy1, 1);
        setReq(0, 5'd2, 32'hDEADBEEF, 1'b1, 1'b1);
        #1;
        chk("of1_gnt", Gnt, 3'b001);
        tick();
        clrReq();
        chk("of1_wren",     WrEn,   1);
        chk("of1_offlag",   OFFlag, 1);
        chk("of1_busy_nobypass", Busy1, 1);
        tick();
        chk("of1_busy_clr", Busy1, 0);
        chk("of1_reg2",     gprRegs[2], 0);
        chk("of1_reg30",    gprRegs[30][0], 1);

        // scoreboard: reserve, stall, same-edge clear+set
        Reserve = 1'b1; ResAddr = 5'd7;
        tick();
        ChkAddr1 = 5'd7;
        #1;
        chk("res7_busy",  Busy1,    1);
        chk("res7_stall", ResStall, 1);
        setReq(1, 5'd7, 32'h00000077, 1'b0, 1'b0);
        #1;
        chk("ld7_gnt",   Gnt,      3'b010);
        chk("ld7_stall", ResStall, 1);
        tick();
        clrReq();
        chk("ld7_wren",         WrEn,     1);
        chk("ld7_stall_commit", ResStall, 0);
        tick();
        Reserve = 1'b0;
        #1;
        chk("ld7_set_wins", Busy1, 1);
        chk("ld7_reg7",     gprRegs[7], 32'h77);

        // reserve to register 0
        Reserve = 1'b1; ResAddr = 5'd0;
        #1;
        chk("res0_stall", ResStall, 0);
        tick();
        Reserve = 1'b0; ChkAddr2 = 5'd0;
        #1;
        chk("res0_busy", Busy2, 0);

        // reset mid-operation (ptr is 2 after the load grant)
        Reserve = 1'b1; ResAddr = 5'd3;
        setReq(1, 5'd9, 32'h99, 1'b0, 1'b0);
        #1;
        chk("pre_gnt", Gnt, 3'b010);
        tick();
        Reserve = 1'b0; clrReq(); ChkAddr1 = 5'd3;
        #1;
        chk("pre_busy3", Busy1, 1);
        chk("pre_wren",  WrEn,  1);
        rst = 1'b1;
        setReq(1, 5'd9, 32'h99, 1'b0, 1'b0);
        setReq(2, 5'd4, 32'h44, 1'b0, 1'b0);
        Reserve = 1'b1; ResAddr = 5'd3;
        #1;
        chk("mid_gnt_zero",   Gnt,      0);
        chk("mid_stall_zero", ResStall, 0);
        tick();
        Reserve = 1'b0;
        chk("mid_wren",   WrEn,   0);
        chk("mid_wraddr", WrAddr, 0);
        chk("mid_busy3",  Busy1,  0);
        rst = 1'b0;
        #1;
        chk("post_gnt",    Gnt,  3'b010);
        chk("post_gnt_fp", GntF, 3'b010);
        tick();
        clrReq();
        chk("post_wraddr", WrAddr, 9);

        $display("%0d/%0d checks passed", nPass, nChk);
        $finish;
    end

endmodule
